// File: rtl/riscv_alu_sched_if.sv
// Shared types and bundled port list for the two-requester ALU scheduler.
//   riscv_alu_sched_pkg : alu_func_t operation encoding (ALU_ADD is the idle code)
//   riscv_alu_sched_if  : request side (req_*), shared-ALU side (alu_*), response side (rsp_*)
//     slave  modport : seen by the scheduler
//     master modport : seen by requesters / ALU / response consumer
package riscv_alu_sched_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_func_t;

endpackage

interface riscv_alu_sched_if #(
  parameter int unsigned TAG_W = 4
);
  import riscv_alu_sched_pkg::*;

  // Request side, one lane per requester
  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [1:0][31:0]       req_a;
  logic [1:0][31:0]       req_b;
  logic [1:0][4:0]        req_shift;
  alu_func_t [1:0]        req_func;
  logic [1:0][TAG_W-1:0]  req_tag;

  // Shared ALU side
  logic [31:0]            alu_a;
  logic [31:0]            alu_b;
  logic [4:0]             alu_shift;
  alu_func_t              alu_func;
  logic [31:0]            alu_result;

  // Response side
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic                   rsp_id;
  logic [TAG_W-1:0]       rsp_tag;
  logic [31:0]            rsp_result;

  modport slave (
    input  req_valid, req_a, req_b, req_shift, req_func, req_tag,
    input  alu_result, rsp_ready,
    output req_ready, alu_a, alu_b, alu_shift, alu_func,
    output rsp_valid, rsp_id, rsp_tag, rsp_result
  );

  modport master (
    output req_valid, req_a, req_b, req_shift, req_func, req_tag,
    output alu_result, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_shift, alu_func,
    input  rsp_valid, rsp_id, rsp_tag, rsp_result
  );

endinterface

// File: rtl/riscv_alu_sched.sv
// Two-requester scheduler in front of one shared single-cycle riscv_alu.
// The granted request is muxed onto the ALU combinationally and its result is
// captured into a one-entry response register (latency 1, one result per cycle).
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : riscv_alu_sched_if.slave (req_*, alu_*, rsp_* bundle)
// Config macro: RISCV_ALU_SCHED_RR_EN
//   defined   -> round-robin arbitration (pointer flips to the other requester after each accept)
//   undefined -> fixed priority, requester 0 always wins, no pointer state
module riscv_alu_sched
  import riscv_alu_sched_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  riscv_alu_sched_if.slave   bus
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t             r_state;
  logic [31:0]        r_rsp_result;
  logic               r_rsp_id;
  logic [TAG_W-1:0]   r_rsp_tag;

  logic               w_any;
  logic               w_grant;
  logic               w_can_accept;
  logic               w_accept;

`ifdef RISCV_ALU_SCHED_RR_EN
  logic               r_prio;

  // Contention goes to the pointer; a lone requester always wins
  always_comb begin
    w_grant = 1'b0;
    if (bus.req_valid == 2'b11) begin
      w_grant = r_prio;
    end else begin
      w_grant = bus.req_valid[1];
    end
  end
`else
  // Requester 1 only wins when requester 0 is idle
  always_comb begin
    w_grant = 1'b0;
    if (!bus.req_valid[0]) begin
      w_grant = bus.req_valid[1];
    end
  end
`endif

  assign w_any        = |bus.req_valid;
  assign w_can_accept = (r_state == S_EMPTY) || bus.rsp_ready;
  assign w_accept     = w_can_accept && w_any;

  // Ready is one-hot on the granted lane, only when the response slot frees up
  always_comb begin
    bus.req_ready = 2'b00;
    if (w_accept) begin
      bus.req_ready = w_grant ? 2'b10 : 2'b01;
    end
  end

  // Operand mux to the shared ALU; idle drive is ADD of zeros
  always_comb begin
    bus.alu_a     = 32'd0;
    bus.alu_b     = 32'd0;
    bus.alu_shift = 5'd0;
    bus.alu_func  = ALU_ADD;
    if (w_any) begin
      bus.alu_a     = bus.req_a[w_grant];
      bus.alu_b     = bus.req_b[w_grant];
      bus.alu_shift = bus.req_shift[w_grant];
      bus.alu_func  = bus.req_func[w_grant];
    end
  end

  // Response slot FSM; an accept overrides the drain so back-to-back results stream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_EMPTY;
      r_rsp_result <= 32'd0;
      r_rsp_id     <= 1'b0;
      r_rsp_tag    <= '0;
`ifdef RISCV_ALU_SCHED_RR_EN
      r_prio       <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_state      <= S_FULL;
        r_rsp_result <= bus.alu_result;
        r_rsp_id     <= w_grant;
        r_rsp_tag    <= bus.req_tag[w_grant];
`ifdef RISCV_ALU_SCHED_RR_EN
        r_prio       <= ~w_grant;
`endif
      end else if ((r_state == S_FULL) && bus.rsp_ready) begin
        r_state      <= S_EMPTY;
      end
    end
  end

  assign bus.rsp_valid  = (r_state == S_FULL);
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_tag    = r_rsp_tag;

endmodule

// File: tb/tb_riscv_alu_sched.sv
// Bench for riscv_alu_sched: directed scenarios plus a randomized stretch, all
// checked against a transaction-level model of the scheduler and a behavioural
// ALU that answers the DUT's alu_* drive. Works for both arbitration builds
// (RISCV_ALU_SCHED_RR_EN defined or not).
module tb_riscv_alu_sched;
  import riscv_alu_sched_pkg::*;

  localparam int unsigned TAG_W = 4;

`ifdef RISCV_ALU_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   failures = 0;

  riscv_alu_sched_if #(.TAG_W(TAG_W)) bus ();

  riscv_alu_sched #(.TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input alu_func_t f, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    case (f)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << sh;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  return 32'($signed(a) >>> sh);
      ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'd0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return 32'd0;
    endcase
  endfunction

  // Shared single-cycle ALU seen by the scheduler
  assign bus.alu_result = alu_ref(bus.alu_func, bus.alu_a, bus.alu_b, bus.alu_shift);

  // Transaction-level model state
  bit               m_full = 1'b0;
  logic [31:0]      m_res  = 32'd0;
  bit               m_id   = 1'b0;
  logic [TAG_W-1:0] m_tag  = '0;
  bit               m_ptr  = 1'b0;
  int               accepts = 0;
  int               dut_handshakes = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_req(input int i);
    logic [3:0] f;
    f = 4'($urandom_range(0, 9));
    bus.req_a[i]     = $urandom;
    bus.req_b[i]     = ($urandom_range(0, 3) == 0) ? bus.req_a[i] : $urandom;
    bus.req_shift[i] = 5'($urandom_range(0, 31));
    bus.req_func[i]  = alu_func_t'(f);
    bus.req_tag[i]   = TAG_W'($urandom_range(0, (1 << TAG_W) - 1));
  endtask

  // One clock with the currently driven inputs: check comb outputs mid-cycle,
  // advance the model at the edge, then check the response registers.
  task automatic cycle(input string tag);
    bit               any, g, can, acc, hs;
    logic [1:0]       exp_rdy;
    logic [31:0]      new_res;
    logic [TAG_W-1:0] new_tag;
    #4;
    any = |bus.req_valid;
    if (bus.req_valid == 2'b11) g = RR ? m_ptr : 1'b0;
    else                        g = bus.req_valid[1];
    can = !m_full || bus.rsp_ready;
    acc = can && any;
    exp_rdy = acc ? (g ? 2'b10 : 2'b01) : 2'b00;
    chk({tag, ":req_ready"}, 64'(bus.req_ready), 64'(exp_rdy));
    if (any) begin
      chk({tag, ":alu_a"},     64'(bus.alu_a),     64'(bus.req_a[g]));
      chk({tag, ":alu_b"},     64'(bus.alu_b),     64'(bus.req_b[g]));
      chk({tag, ":alu_shift"}, 64'(bus.alu_shift), 64'(bus.req_shift[g]));
      chk({tag, ":alu_func"},  64'(bus.alu_func),  64'(bus.req_func[g]));
    end else begin
      chk({tag, ":idle_a"},    64'(bus.alu_a),     64'd0);
      chk({tag, ":idle_b"},    64'(bus.alu_b),     64'd0);
      chk({tag, ":idle_func"}, 64'(bus.alu_func),  64'(ALU_ADD));
    end
    new_res = alu_ref(bus.req_func[g], bus.req_a[g], bus.req_b[g], bus.req_shift[g]);
    new_tag = bus.req_tag[g];
    hs = bus.rsp_valid && bus.rsp_ready;
    @(posedge clk);
    if (hs) dut_handshakes++;
    if (acc) begin
      m_full = 1'b1;
      m_res  = new_res;
      m_id   = g;
      m_tag  = new_tag;
      accepts++;
      if (RR) m_ptr = ~g;
    end else if (m_full && bus.rsp_ready) begin
      m_full = 1'b0;
    end
    #1;
    chk({tag, ":rsp_valid"}, 64'(bus.rsp_valid), 64'(m_full));
    if (m_full) begin
      chk({tag, ":rsp_result"}, 64'(bus.rsp_result), 64'(m_res));
      chk({tag, ":rsp_id"},     64'(bus.rsp_id),     64'(m_id));
      chk({tag, ":rsp_tag"},    64'(bus.rsp_tag),    64'(m_tag));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid  = 2'b00;
    bus.rsp_ready  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.req_a[i]     = 32'd0;
      bus.req_b[i]     = 32'd0;
      bus.req_shift[i] = 5'd0;
      bus.req_func[i]  = ALU_ADD;
      bus.req_tag[i]   = '0;
    end

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    chk("reset:rsp_valid",  64'(bus.rsp_valid),  64'd0);
    chk("reset:rsp_result", 64'(bus.rsp_result), 64'd0);
    chk("reset:rsp_id",     64'(bus.rsp_id),     64'd0);
    chk("reset:rsp_tag",    64'(bus.rsp_tag),    64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle drive
    bus.rsp_ready = 1'b1;
    cycle("idle");

    // Single request: req0 ADD 5+3
    bus.req_a[0] = 32'd5; bus.req_b[0] = 32'd3; bus.req_shift[0] = 5'd0;
    bus.req_func[0] = ALU_ADD; bus.req_tag[0] = 4'hA;
    bus.req_valid = 2'b01;
    cycle("single");
    chk("single:valid",  64'(bus.rsp_valid),  64'd1);
    chk("single:result", 64'(bus.rsp_result), 64'd8);
    chk("single:id",     64'(bus.rsp_id),     64'd0);
    chk("single:tag",    64'(bus.rsp_tag),    64'hA);
    bus.req_valid = 2'b00;
    cycle("drain");
    chk("drain:empty", 64'(bus.rsp_valid), 64'd0);

    // Lone requester 1 wins (and hands the pointer back to requester 0)
    rand_req(1);
    bus.req_valid = 2'b10;
    cycle("lone1");
    chk("lone1:id", 64'(bus.rsp_id), 64'd1);

    // Contention for 4 cycles with rsp_ready held high
    for (int k = 0; k < 4; k++) begin
      rand_req(0);
      rand_req(1);
      bus.req_valid = 2'b11;
      cycle("contend");
      chk("contend:grant_seq", 64'(bus.rsp_id), RR ? 64'(k % 2) : 64'd0);
    end

    // Backpressure with a SUB result of 0xFFFFFFFE held in the slot
    bus.req_valid = 2'b01;
    bus.req_a[0] = 32'd1; bus.req_b[0] = 32'd3; bus.req_func[0] = ALU_SUB;
    bus.req_tag[0] = 4'h5;
    bus.rsp_ready = 1'b1;
    cycle("bp_load");
    chk("bp_load:result", 64'(bus.rsp_result), 64'hFFFF_FFFE);
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rand_req(0);
      rand_req(1);
      bus.req_valid = 2'b11;
      cycle("bp_hold");
      chk("bp_hold:result", 64'(bus.rsp_result), 64'hFFFF_FFFE);
      chk("bp_hold:tag",    64'(bus.rsp_tag),    64'h5);
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    cycle("bp_release");
    chk("bp_release:empty", 64'(bus.rsp_valid), 64'd0);

    // Randomized traffic with random backpressure
    for (int k = 0; k < 300; k++) begin
      rand_req(0);
      rand_req(1);
      bus.req_valid = 2'($urandom_range(0, 3));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      cycle("rand");
    end

    // Reset while FULL discards the pending response immediately
    rand_req(0);
    bus.req_valid = 2'b01;
    bus.rsp_ready = 1'b0;
    cycle("pre_rst");
    chk("pre_rst:full", 64'(bus.rsp_valid), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid:rsp_valid",  64'(bus.rsp_valid),  64'd0);
    chk("rst_mid:rsp_result", 64'(bus.rsp_result), 64'd0);
    chk("rst_mid:rsp_tag",    64'(bus.rsp_tag),    64'd0);
    m_full = 1'b0;
    m_ptr  = 1'b0;
    accepts--;
    @(posedge clk);
    #1 rst_n = 1'b1;
    rand_req(0);
    rand_req(1);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    cycle("post_rst");
    chk("post_rst:id", 64'(bus.rsp_id), 64'd0);
    bus.req_valid = 2'b00;
    cycle("final_drain");

    // Every accepted (non-discarded) request produced exactly one handshake
    chk("rsp_count", 64'(dut_handshakes), 64'(accepts));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
